// File: rtl/trigger_pulse_gen.sv
// Trigger pulse-train generator: on a pattern match, emits up to pNUM_TRIGGER_PULSES
// pulses with per-pulse delay and width taken from a snapshot of the settings.
module trigger_pulse_gen #(
  parameter int pNUM_TRIGGER_PULSES = 8,
  parameter int pNUM_TRIGGER_WIDTH  = 4,
  parameter int pCOUNT_WIDTH        = 24
) (
  input  logic                                          trigger_clk,
  input  logic                                          reset_i,
  input  logic                                          I_match,
  input  logic                                          I_trigger_enable,
  input  logic [pNUM_TRIGGER_WIDTH-1:0]                 I_num_triggers,
  input  logic [pCOUNT_WIDTH*pNUM_TRIGGER_PULSES-1:0]   I_trigger_delay,
  input  logic [pCOUNT_WIDTH*pNUM_TRIGGER_PULSES-1:0]   I_trigger_width,
  output logic                                          O_trigger,
  output logic                                          O_busy,
  output logic                                          O_done,
  output logic [pNUM_TRIGGER_WIDTH-1:0]                 O_pulse_index
);

  localparam int TOT_W = pCOUNT_WIDTH * pNUM_TRIGGER_PULSES;
  localparam logic [pNUM_TRIGGER_WIDTH-1:0] MAX_PULSES = pNUM_TRIGGER_WIDTH'(pNUM_TRIGGER_PULSES);
  localparam logic [pNUM_TRIGGER_WIDTH-1:0] IDX_ONE    = pNUM_TRIGGER_WIDTH'(1);
  localparam logic [pCOUNT_WIDTH-1:0]       CNT_ONE    = pCOUNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, DELAY, PULSE, DONE} state_t;

  state_t                        state;
  logic [pCOUNT_WIDTH-1:0]       cnt;
  logic [TOT_W-1:0]              delay_snap;
  logic [TOT_W-1:0]              width_snap;
  logic [pNUM_TRIGGER_WIDTH-1:0] count_snap;
  logic [pNUM_TRIGGER_WIDTH-1:0] idx;

  logic [pNUM_TRIGGER_WIDTH-1:0] idx_next;
  logic [pCOUNT_WIDTH-1:0]       first_delay;
  logic [pCOUNT_WIDTH-1:0]       first_width;
  logic [pCOUNT_WIDTH-1:0]       cur_width;
  logic [pCOUNT_WIDTH-1:0]       next_delay;
  logic [pCOUNT_WIDTH-1:0]       next_width;

  function automatic logic [pNUM_TRIGGER_WIDTH-1:0] clamp_count(
    input logic [pNUM_TRIGGER_WIDTH-1:0] n
  );
    if (n == '0)
      return IDX_ONE;
    else if (n > MAX_PULSES)
      return MAX_PULSES;
    else
      return n;
  endfunction

  // Counter preload for a pulse: width 0 behaves as a one-cycle pulse.
  function automatic logic [pCOUNT_WIDTH-1:0] width_load(
    input logic [pCOUNT_WIDTH-1:0] w
  );
    if (w == '0)
      return '0;
    else
      return w - CNT_ONE;
  endfunction

  function automatic logic [pCOUNT_WIDTH-1:0] field(
    input logic [TOT_W-1:0]              v,
    input logic [pNUM_TRIGGER_WIDTH-1:0] i
  );
    if (int'(i) >= pNUM_TRIGGER_PULSES)
      return '0;
    else
      return v[int'(i)*pCOUNT_WIDTH +: pCOUNT_WIDTH];
  endfunction

  always_comb begin
    idx_next    = idx + IDX_ONE;
    first_delay = field(I_trigger_delay, '0);
    first_width = field(I_trigger_width, '0);
    cur_width   = field(width_snap, idx);
    next_delay  = field(delay_snap, idx_next);
    next_width  = field(width_snap, idx_next);
  end

  // Outputs are registered alongside the state so they follow the state exactly.
  always_ff @(posedge trigger_clk) begin
    if (reset_i) begin
      state         <= IDLE;
      cnt           <= '0;
      delay_snap    <= '0;
      width_snap    <= '0;
      count_snap    <= '0;
      idx           <= '0;
      O_trigger     <= 1'b0;
      O_busy        <= 1'b0;
      O_done        <= 1'b0;
      O_pulse_index <= '0;
    end else begin
      O_done <= 1'b0;
      case (state)
        IDLE: begin
          O_trigger     <= 1'b0;
          O_busy        <= 1'b0;
          O_pulse_index <= '0;
          if (I_match && I_trigger_enable) begin
            delay_snap <= I_trigger_delay;
            width_snap <= I_trigger_width;
            count_snap <= clamp_count(I_num_triggers);
            idx        <= '0;
            O_busy     <= 1'b1;
            if (first_delay == '0) begin
              state     <= PULSE;
              cnt       <= width_load(first_width);
              O_trigger <= 1'b1;
            end else begin
              state <= DELAY;
              cnt   <= first_delay;
            end
          end
        end

        DELAY: begin
          if (!I_trigger_enable) begin
            state         <= IDLE;
            idx           <= '0;
            O_trigger     <= 1'b0;
            O_busy        <= 1'b0;
            O_pulse_index <= '0;
          end else if (cnt == CNT_ONE) begin
            state     <= PULSE;
            cnt       <= width_load(cur_width);
            O_trigger <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        PULSE: begin
          if (!I_trigger_enable) begin
            state         <= IDLE;
            idx           <= '0;
            O_trigger     <= 1'b0;
            O_busy        <= 1'b0;
            O_pulse_index <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (idx_next < count_snap) begin
            idx           <= idx_next;
            O_pulse_index <= idx_next;
            // A zero delay chains straight into the next pulse, merging them.
            if (next_delay == '0) begin
              state     <= PULSE;
              cnt       <= width_load(next_width);
              O_trigger <= 1'b1;
            end else begin
              state     <= DELAY;
              cnt       <= next_delay;
              O_trigger <= 1'b0;
            end
          end else begin
            state         <= DONE;
            idx           <= '0;
            O_trigger     <= 1'b0;
            O_busy        <= 1'b0;
            O_done        <= 1'b1;
            O_pulse_index <= '0;
          end
        end

        DONE: begin
          state         <= IDLE;
          O_trigger     <= 1'b0;
          O_busy        <= 1'b0;
          O_pulse_index <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Directed bench for trigger_pulse_gen: per-cycle traces after a match compared to hand-built vectors.
module tb_trigger_pulse_gen;

  localparam int NP = 8;
  localparam int NW = 4;
  localparam int CW = 24;

  logic              trigger_clk;
  logic              reset_i;
  logic              I_match;
  logic              I_trigger_enable;
  logic [NW-1:0]     I_num_triggers;
  logic [CW*NP-1:0]  I_trigger_delay;
  logic [CW*NP-1:0]  I_trigger_width;
  logic              O_trigger;
  logic              O_busy;
  logic              O_done;
  logic [NW-1:0]     O_pulse_index;

  int total;
  int bad;

  logic [63:0] trig_v;
  logic [63:0] busy_v;
  logic [63:0] done_v;
  logic [NW-1:0] idx_a [64];

  trigger_pulse_gen #(
    .pNUM_TRIGGER_PULSES(NP),
    .pNUM_TRIGGER_WIDTH (NW),
    .pCOUNT_WIDTH       (CW)
  ) dut (
    .trigger_clk     (trigger_clk),
    .reset_i         (reset_i),
    .I_match         (I_match),
    .I_trigger_enable(I_trigger_enable),
    .I_num_triggers  (I_num_triggers),
    .I_trigger_delay (I_trigger_delay),
    .I_trigger_width (I_trigger_width),
    .O_trigger       (O_trigger),
    .O_busy          (O_busy),
    .O_done          (O_done),
    .O_pulse_index   (O_pulse_index)
  );

  initial trigger_clk = 1'b0;
  always #5 trigger_clk = ~trigger_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cfg_all(input logic [NW-1:0] n, input int d, input int w);
    I_num_triggers = n;
    for (int i = 0; i < NP; i++) begin
      I_trigger_delay[i*CW +: CW] = CW'(d);
      I_trigger_width[i*CW +: CW] = CW'(w);
    end
  endtask

  task automatic cfg_pulse(input int i, input int d, input int w);
    I_trigger_delay[i*CW +: CW] = CW'(d);
    I_trigger_width[i*CW +: CW] = CW'(w);
  endtask

  // Called right after a posedge. Fires a match sampled at the next edge (T), then records
  // cycles T+1..T+n. Optional per-cycle events: rematch, enable drop, reset pulse, delay rewrite.
  task automatic run(input int n, input int match_at, input int drop_at,
                     input int rst_at, input int wr_at);
    trig_v = '0;
    busy_v = '0;
    done_v = '0;
    #1;
    I_match = 1'b1;
    @(posedge trigger_clk);
    for (int k = 1; k <= n; k++) begin
      #1;
      trig_v[k] = O_trigger;
      busy_v[k] = O_busy;
      done_v[k] = O_done;
      idx_a[k]  = O_pulse_index;
      I_match = (k == match_at);
      reset_i = (k == rst_at);
      if (k == drop_at) I_trigger_enable = 1'b0;
      if (k == wr_at) cfg_all(4'd2, 0, 0);
      @(posedge trigger_clk);
    end
    #1;
    I_match = 1'b0;
    reset_i = 1'b0;
    @(posedge trigger_clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_i = 1'b1;
    I_match = 1'b0;
    I_trigger_enable = 1'b1;
    cfg_all(4'd1, 0, 0);
    repeat (3) @(posedge trigger_clk);
    #1;
    check("rst_trig", 64'(O_trigger), 64'd0);
    check("rst_busy", 64'(O_busy), 64'd0);
    check("rst_done", 64'(O_done), 64'd0);
    check("rst_idx", 64'(O_pulse_index), 64'd0);
    reset_i = 1'b0;
    @(posedge trigger_clk);

    // single pulse: delay 5, width 3
    cfg_all(4'd1, 9, 9);
    cfg_pulse(0, 5, 3);
    run(14, 0, 0, 0, 0);
    check("t1_trig", trig_v, 64'h1C0);
    check("t1_busy", busy_v, 64'h1FE);
    check("t1_done", done_v, 64'h200);

    // three pulses, last two merged
    cfg_all(4'd3, 7, 7);
    cfg_pulse(0, 0, 1);
    cfg_pulse(1, 2, 2);
    cfg_pulse(2, 0, 4);
    run(14, 0, 0, 0, 0);
    check("t2_trig", trig_v, 64'h3F2);
    check("t2_busy", busy_v, 64'h3FE);
    check("t2_done", done_v, 64'h400);
    check("t2_idx1", 64'(idx_a[1]), 64'd0);
    check("t2_idx3", 64'(idx_a[3]), 64'd1);
    check("t2_idx7", 64'(idx_a[7]), 64'd2);

    // count 0 -> one pulse, width 0 -> one cycle
    cfg_all(4'd0, 3, 3);
    cfg_pulse(0, 1, 0);
    run(8, 0, 0, 0, 0);
    check("t3a_trig", trig_v, 64'h4);
    check("t3a_done", done_v, 64'h8);

    // count 15 clamps to 8 pulses
    cfg_all(4'd15, 1, 1);
    run(20, 0, 0, 0, 0);
    check("t3b_trig", trig_v, 64'h15554);
    check("t3b_busy", busy_v, 64'h1FFFE);
    check("t3b_done", done_v, 64'h20000);
    check("t3b_idx16", 64'(idx_a[16]), 64'd7);

    // second match during delay of pulse 0 is ignored
    cfg_all(4'd1, 9, 9);
    cfg_pulse(0, 5, 3);
    run(14, 2, 0, 0, 0);
    check("t4_trig", trig_v, 64'h1C0);
    check("t4_done", done_v, 64'h200);

    // enable dropped during pulse 1 of 4
    cfg_all(4'd4, 1, 3);
    run(12, 0, 6, 0, 0);
    check("t5_trig", trig_v, 64'h5C);
    check("t5_busy", busy_v, 64'h7E);
    check("t5_done", done_v, 64'h0);
    check("t5_idx6", 64'(idx_a[6]), 64'd1);
    I_trigger_enable = 1'b1;
    run(20, 0, 0, 0, 0);
    check("t5r_idx1", 64'(idx_a[1]), 64'd0);
    check("t5r_trig", trig_v, 64'h1DDDC);
    check("t5r_done", done_v, 64'h20000);

    // settings rewritten mid-sequence
    cfg_all(4'd1, 9, 9);
    cfg_pulse(0, 5, 3);
    run(14, 0, 0, 0, 2);
    check("t6a_trig", trig_v, 64'h1C0);
    check("t6a_done", done_v, 64'h200);

    // reset mid-pulse
    cfg_all(4'd1, 9, 9);
    cfg_pulse(0, 5, 3);
    run(14, 0, 0, 7, 0);
    check("t6b_trig", trig_v, 64'hC0);
    check("t6b_busy", busy_v, 64'hFE);
    check("t6b_done", done_v, 64'h0);
    check("t6b_idx8", 64'(idx_a[8]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
